// File: rtl/bp_table_scheduler.sv
// Branch prediction table scheduler: sole owner of the single-ported table. Sweeps the
// table after reset, then arbitrates IF lookups against buffered EX read-modify-write updates.
module bp_table_scheduler #(
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [1:0]  INIT_CNT   = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [31:0]      lookup_pc,
    output logic             lookup_ready,
    output logic             pred_valid,
    output logic             take_branch,
    output logic [31:0]      predicted_destination,
    input  logic             feedback_valid,
    input  logic [31:0]      branch_pc,
    input  logic             branch_taken,
    input  logic [31:0]      correct_destination,
    output logic             feedback_ready,
    output logic             init_done,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_idx,
    output logic [33:0]      tbl_wdata,
    input  logic [33:0]      tbl_rdata
);

    localparam int unsigned TGT_W    = 32;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W    = PTR_W + 1;
    localparam int unsigned LAST_IDX = (1 << IDX_W) - 1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_RD = 2'd2,
        ST_UPD_WR = 2'd3
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic [TGT_W-1:0] dest;
    } upd_t;

    state_t             state, state_nx;
    logic               init_go;
    logic [IDX_W-1:0]   init_idx, init_idx_nx;
    logic               init_done_nx;
    logic               accept;
    logic               take_q;
    logic [TGT_W-1:0]   dest_q;

    upd_t               fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic               full, empty, push, pop;
    upd_t               head;

    logic [1:0]         old_cnt, new_cnt;
    logic [TGT_W-1:0]   new_tgt;
    logic               unused_pc_bits;

    assign full           = (occ == OCC_W'(FIFO_DEPTH));
    assign empty          = (occ == '0);
    assign feedback_ready = init_done && !full;
    assign push           = feedback_valid && feedback_ready;
    assign head           = fifo_mem[rd_ptr];

    // Prediction is presented straight from the table in the response cycle, then held.
    assign take_branch           = pred_valid ? tbl_rdata[33]      : take_q;
    assign predicted_destination = pred_valid ? tbl_rdata[31:0]    : dest_q;

    assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                              branch_pc[31:IDX_W+2], branch_pc[1:0]};

    // Saturating counter and target merge for the head update.
    always_comb begin
        old_cnt = tbl_rdata[33:32];
        new_cnt = old_cnt;
        if (head.taken) begin
            if (old_cnt != 2'b11) new_cnt = old_cnt + 2'b01;
        end else begin
            if (old_cnt != 2'b00) new_cnt = old_cnt - 2'b01;
        end
        new_tgt = head.taken ? head.dest : tbl_rdata[31:0];
    end

    always_comb begin
        state_nx     = state;
        init_idx_nx  = init_idx;
        init_done_nx = init_done;
        lookup_ready = 1'b0;
        accept       = 1'b0;
        pop          = 1'b0;
        tbl_en       = 1'b0;
        tbl_we       = 1'b0;
        tbl_idx      = '0;
        tbl_wdata    = '0;
        case (state)
            ST_INIT: begin
                // init_go keeps the table strobes quiet while reset is applied.
                if (init_go) begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_idx   = init_idx;
                    tbl_wdata = {INIT_CNT, TGT_W'(0)};
                    if (init_idx == IDX_W'(LAST_IDX)) begin
                        state_nx     = ST_IDLE;
                        init_done_nx = 1'b1;
                    end else begin
                        init_idx_nx = init_idx + IDX_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                // A full buffer pre-empts lookups so updates cannot starve.
                if (full) begin
                    state_nx = ST_UPD_RD;
                end else begin
                    lookup_ready = 1'b1;
                    if (lookup_valid) begin
                        accept  = 1'b1;
                        tbl_en  = 1'b1;
                        tbl_idx = lookup_pc[IDX_W+1:2];
                    end else if (!empty) begin
                        state_nx = ST_UPD_RD;
                    end
                end
            end
            ST_UPD_RD: begin
                tbl_en   = 1'b1;
                tbl_idx  = head.idx;
                state_nx = ST_UPD_WR;
            end
            ST_UPD_WR: begin
                tbl_en    = 1'b1;
                tbl_we    = 1'b1;
                tbl_idx   = head.idx;
                tbl_wdata = {new_cnt, new_tgt};
                pop       = 1'b1;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            init_go    <= 1'b0;
            init_idx   <= '0;
            init_done  <= 1'b0;
            pred_valid <= 1'b0;
            take_q     <= 1'b0;
            dest_q     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
        end else begin
            state      <= state_nx;
            init_go    <= 1'b1;
            init_idx   <= init_idx_nx;
            init_done  <= init_done_nx;
            pred_valid <= accept;
            if (pred_valid) begin
                take_q <= tbl_rdata[33];
                dest_q <= tbl_rdata[31:0];
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Update buffer storage; contents are only meaningful below occ.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{idx:   branch_pc[IDX_W+1:2],
                                  taken: branch_taken,
                                  dest:  correct_destination};
        end
    end

endmodule
